// File: rtl/axi_infrastructure_v1_1_payload_slice.sv
// Single-channel register slice for a packed AXI payload vector.
// Modes: 0 = combinational bypass, 1 = two-entry skid buffer (full rate),
// 7 = one-entry light slice (half rate). Unknown modes fall back to bypass.
module axi_infrastructure_v1_1_payload_slice #(
    parameter int C_PAYLOAD_WIDTH = 61,
    parameter int C_REG_CONFIG    = 1
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [C_PAYLOAD_WIDTH-1:0] s_payload,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [C_PAYLOAD_WIDTH-1:0] m_payload,
    output logic                       m_valid,
    input  logic                       m_ready
);

    localparam int MODE = (C_REG_CONFIG == 1) ? 1 :
                          (C_REG_CONFIG == 7) ? 7 : 0;

    // Occupancy of the skid buffer: nothing, main register only, main + skid.
    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_FULL
    } skid_state_t;

    // Occupancy of the light slice.
    typedef enum logic {
        LIGHT_EMPTY,
        LIGHT_FULL
    } light_state_t;

    generate
        if (MODE == 1) begin : g_skid
            skid_state_t                state;
            logic [C_PAYLOAD_WIDTH-1:0] main_q;
            logic [C_PAYLOAD_WIDTH-1:0] skid_q;
            logic                       valid_q;
            logic                       ready_q;
            logic                       hold_q;
            logic                       s_xfer;
            logic                       m_xfer;

            // Handshakes are formed only from registered outputs, so neither
            // ready nor valid has a combinational path through the slice.
            assign s_xfer = s_valid & ready_q;
            assign m_xfer = valid_q & m_ready;

            // Occupancy FSM; m_valid and s_ready are registered state outputs.
            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    state   <= SKID_EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b0;
                    hold_q  <= 1'b1;
                end else begin
                    hold_q <= 1'b0;
                    case (state)
                        SKID_EMPTY: begin
                            // The first edge out of reset keeps s_ready low.
                            ready_q <= !hold_q;
                            if (s_xfer) begin
                                state   <= SKID_ONE;
                                valid_q <= 1'b1;
                            end
                        end
                        SKID_ONE: begin
                            if (s_xfer && !m_xfer) begin
                                state   <= SKID_FULL;
                                ready_q <= 1'b0;
                            end else if (m_xfer && !s_xfer) begin
                                state   <= SKID_EMPTY;
                                valid_q <= 1'b0;
                            end
                        end
                        SKID_FULL: begin
                            if (m_xfer) begin
                                state   <= SKID_ONE;
                                ready_q <= 1'b1;
                            end
                        end
                        default: begin
                            state   <= SKID_EMPTY;
                            valid_q <= 1'b0;
                            ready_q <= 1'b0;
                        end
                    endcase
                end
            end

            // Payload storage; not reset, contents only matter while valid.
            always_ff @(posedge aclk) begin
                case (state)
                    SKID_EMPTY: begin
                        if (s_xfer) main_q <= s_payload;
                    end
                    SKID_ONE: begin
                        // Simultaneous in/out refreshes the main register;
                        // an incoming beat under stall parks in the skid.
                        if (s_xfer && m_xfer) main_q <= s_payload;
                        else if (s_xfer)      skid_q <= s_payload;
                    end
                    SKID_FULL: begin
                        if (m_xfer) main_q <= skid_q;
                    end
                    default: begin
                    end
                endcase
            end

            assign m_payload = main_q;
            assign m_valid   = valid_q;
            assign s_ready   = ready_q;
        end else if (MODE == 7) begin : g_light
            light_state_t               state;
            logic [C_PAYLOAD_WIDTH-1:0] data_q;
            logic                       valid_q;
            logic                       ready_q;
            logic                       hold_q;
            logic                       s_xfer;
            logic                       m_xfer;

            assign s_xfer = s_valid & ready_q;
            assign m_xfer = valid_q & m_ready;

            // Single-entry FSM; ready and valid are mutually exclusive registers.
            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    state   <= LIGHT_EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b0;
                    hold_q  <= 1'b1;
                end else begin
                    case (state)
                        LIGHT_EMPTY: begin
                            if (hold_q) begin
                                hold_q  <= 1'b0;
                                ready_q <= 1'b0;
                            end else if (s_xfer) begin
                                state   <= LIGHT_FULL;
                                valid_q <= 1'b1;
                                ready_q <= 1'b0;
                            end else begin
                                ready_q <= 1'b1;
                            end
                        end
                        LIGHT_FULL: begin
                            if (m_xfer) begin
                                state   <= LIGHT_EMPTY;
                                valid_q <= 1'b0;
                                ready_q <= 1'b1;
                            end
                        end
                        default: begin
                            state   <= LIGHT_EMPTY;
                            valid_q <= 1'b0;
                            ready_q <= 1'b0;
                        end
                    endcase
                end
            end

            // Payload capture on accept; not reset.
            always_ff @(posedge aclk) begin
                if (s_xfer) data_q <= s_payload;
            end

            assign m_payload = data_q;
            assign m_valid   = valid_q;
            assign s_ready   = ready_q;
        end else begin : g_bypass
            // Pure wires: clock and reset are intentionally unused here.
            logic bypass_unused;
            assign bypass_unused = &{1'b0, aclk, aresetn};

            assign m_payload = s_payload;
            assign m_valid   = s_valid;
            assign s_ready   = m_ready;
        end
    endgenerate

endmodule

// File: tb/tb_axi_infrastructure_v1_1_payload_slice.sv
// Scoreboard bench for the payload slice: skid (mode 1), light (mode 7),
// bypass (mode 0) and an unsupported mode (3) that must behave as bypass.
module tb_axi_infrastructure_v1_1_payload_slice;

    localparam int W  = 16;
    localparam int WB = 61;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Index 0 = skid slice, index 1 = light slice.
    logic [W-1:0] sp   [2];
    logic         sv   [2];
    logic         sr   [2];
    logic [W-1:0] mp   [2];
    logic         mv   [2];
    logic         mr   [2];
    logic         rstn [2];

    logic [WB-1:0] bp_sp;
    logic          bp_sv, bp_mr, bp_rstn;
    logic [WB-1:0] b0_mp, b3_mp;
    logic          b0_mv, b0_sr, b3_mv, b3_sr;

    axi_infrastructure_v1_1_payload_slice #(.C_PAYLOAD_WIDTH(W), .C_REG_CONFIG(1)) dut_skid (
        .aclk(clk), .aresetn(rstn[0]), .s_payload(sp[0]), .s_valid(sv[0]), .s_ready(sr[0]),
        .m_payload(mp[0]), .m_valid(mv[0]), .m_ready(mr[0]));

    axi_infrastructure_v1_1_payload_slice #(.C_PAYLOAD_WIDTH(W), .C_REG_CONFIG(7)) dut_light (
        .aclk(clk), .aresetn(rstn[1]), .s_payload(sp[1]), .s_valid(sv[1]), .s_ready(sr[1]),
        .m_payload(mp[1]), .m_valid(mv[1]), .m_ready(mr[1]));

    axi_infrastructure_v1_1_payload_slice #(.C_PAYLOAD_WIDTH(WB), .C_REG_CONFIG(0)) dut_bypass (
        .aclk(clk), .aresetn(bp_rstn), .s_payload(bp_sp), .s_valid(bp_sv), .s_ready(b0_sr),
        .m_payload(b0_mp), .m_valid(b0_mv), .m_ready(bp_mr));

    axi_infrastructure_v1_1_payload_slice #(.C_PAYLOAD_WIDTH(WB), .C_REG_CONFIG(3)) dut_odd (
        .aclk(clk), .aresetn(bp_rstn), .s_payload(bp_sp), .s_valid(bp_sv), .s_ready(b3_sr),
        .m_payload(b3_mp), .m_valid(b3_mv), .m_ready(bp_mr));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an in-order queue with a capacity per slice and a
    // count of edges that s_ready stays low after reset.
    logic [W-1:0] sb [2][$];
    int  cap [2] = '{2, 1};
    int  rcnt [2] = '{0, 0};
    bit  started [2] = '{1'b0, 1'b0};
    bit  acc [2] = '{1'b0, 1'b0};
    int  mx_cnt [2] = '{0, 0};

    // Monitor: compare DUT outputs with the model and retire output beats.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            acc[k] = 1'b0;
            if (started[k]) begin
                chk($sformatf("s_ready[%0d]", k), {63'd0, sr[k]},
                    {63'd0, (rcnt[k] == 0 && sb[k].size() < cap[k])});
                chk($sformatf("m_valid[%0d]", k), {63'd0, mv[k]}, {63'd0, (sb[k].size() > 0)});
                if (mv[k] === 1'b1 && sb[k].size() > 0) begin
                    chk($sformatf("m_payload[%0d]", k), {48'd0, mp[k]}, {48'd0, sb[k][0]});
                    if (mr[k] === 1'b1) begin
                        void'(sb[k].pop_front());
                        mx_cnt[k]++;
                    end
                end
                acc[k] = (sv[k] === 1'b1 && sr[k] === 1'b1);
            end
        end
    end

    // Model update at the clock edge: accepted beats enter, reset flushes.
    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (acc[k]) sb[k].push_back(sp[k]);
            if (rstn[k] === 1'b0) begin
                sb[k].delete();
                rcnt[k]    = 2;
                started[k] = 1'b1;
            end else if (rcnt[k] > 0) begin
                rcnt[k]--;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one beat; called and returns just after a rising edge.
    task automatic send(input int k, input logic [W-1:0] v, input int limit, output bit ok);
        sp[k] = v;
        sv[k] = 1'b1;
        ok    = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (sr[k] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_drive(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            if (!sv[k] || acc[k]) begin
                sv[k] = ($urandom_range(0, 3) != 0);
                sp[k] = W'($urandom);
            end
            mr[k]   = ($urandom_range(0, 3) != 0);
            rstn[k] = ($urandom_range(0, 79) != 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bypass_run(input int n);
        logic [63:0] r;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            r       = {$urandom, $urandom};
            bp_sp   = r[WB-1:0];
            bp_sv   = 1'($urandom);
            bp_mr   = 1'($urandom);
            bp_rstn = 1'($urandom);
            @(negedge clk);
            chk("bypass_payload", {3'd0, b0_mp}, {3'd0, bp_sp});
            chk("bypass_valid", {63'd0, b0_mv}, {63'd0, bp_sv});
            chk("bypass_ready", {63'd0, b0_sr}, {63'd0, bp_mr});
            chk("mode3_payload", {3'd0, b3_mp}, {3'd0, bp_sp});
            chk("mode3_valid", {63'd0, b3_mv}, {63'd0, bp_sv});
            chk("mode3_ready", {63'd0, b3_sr}, {63'd0, bp_mr});
        end
    endtask

    task automatic directed_and_random();
        bit ok;
        int t0, base;
        // Reset release with a beat already offered.
        cycles(3);
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;
        t0 = cyc;
        send(0, 16'h00A5, 10, ok);
        chk("release_accept", {63'd0, ok}, 64'd1);
        chk("release_latency", 64'(cyc - t0), 64'd3);
        sv[0] = 1'b0;
        cycles(3);
        chk("release_out", 64'(mx_cnt[0]), 64'd1);

        // Streaming 16 beats at full rate.
        base = mx_cnt[0];
        t0   = cyc;
        for (int i = 0; i < 16; i++) begin
            send(0, W'(i), 4, ok);
            chk("stream_accept", {63'd0, ok}, 64'd1);
        end
        chk("stream_cycles", 64'(cyc - t0), 64'd16);
        sv[0] = 1'b0;
        cycles(2);
        chk("stream_out", 64'(mx_cnt[0] - base), 64'd16);

        // Backpressure: two beats held, third waits upstream.
        mr[0] = 1'b0;
        base  = mx_cnt[0];
        send(0, 16'h0011, 4, ok);
        chk("bp_accept_11", {63'd0, ok}, 64'd1);
        send(0, 16'h0022, 4, ok);
        chk("bp_accept_22", {63'd0, ok}, 64'd1);
        fork
            begin
                bit ok3;
                send(0, 16'h0033, 20, ok3);
                chk("bp_accept_33", {63'd0, ok3}, 64'd1);
            end
            begin
                @(negedge clk);
                chk("bp_ready_low", {63'd0, sr[0]}, 64'd0);
                cycles(4);
                mr[0] = 1'b1;
            end
        join
        sv[0] = 1'b0;
        cycles(4);
        chk("bp_out", 64'(mx_cnt[0] - base), 64'd3);

        // Light mode: 8 beats in 16 cycles.
        mr[1] = 1'b1;
        base  = mx_cnt[1];
        t0    = cyc;
        for (int i = 0; i < 8; i++) begin
            send(1, W'(16'h0100 + i), 4, ok);
            chk("light_accept", {63'd0, ok}, 64'd1);
        end
        while (cyc < t0 + 16) @(posedge clk);
        #1;
        sv[1] = 1'b0;
        chk("light_out16", 64'(mx_cnt[1] - base), 64'd8);

        // Reset while FULL discards held beats.
        mr[0] = 1'b0;
        send(0, 16'h00C1, 4, ok);
        send(0, 16'h00C2, 4, ok);
        sv[0]   = 1'b0;
        rstn[0] = 1'b0;
        cycles(1);
        rstn[0] = 1'b1;
        @(negedge clk);
        chk("rst_mvalid", {63'd0, mv[0]}, 64'd0);
        chk("rst_sready", {63'd0, sr[0]}, 64'd0);
        @(posedge clk);
        #1;
        base  = mx_cnt[0];
        mr[0] = 1'b1;
        send(0, 16'h005A, 10, ok);
        chk("rst_accept_5a", {63'd0, ok}, 64'd1);
        sv[0] = 1'b0;
        cycles(3);
        chk("rst_out_5a", 64'(mx_cnt[0] - base), 64'd1);

        // Randomized traffic with occasional resets on both slices.
        base = mx_cnt[0] + mx_cnt[1];
        fork
            rand_drive(0, 300);
            rand_drive(1, 300);
        join
        for (int k = 0; k < 2; k++) begin
            sv[k] = 1'b0;
            mr[k] = 1'b1;
            rstn[k] = 1'b1;
        end
        cycles(10);
        chk("rand_progress", {63'd0, (mx_cnt[0] + mx_cnt[1] - base) > 40}, 64'd1);
        chk("drain_skid", 64'(sb[0].size()), 64'd0);
        chk("drain_light", 64'(sb[1].size()), 64'd0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            sp[k] = '0; sv[k] = 1'b0; mr[k] = 1'b0; rstn[k] = 1'b0;
        end
        sp[0] = 16'h00A5;
        sv[0] = 1'b1;
        mr[0] = 1'b1;
        bp_sp = '0; bp_sv = 1'b0; bp_mr = 1'b0; bp_rstn = 1'b0;
        fork
            directed_and_random();
            bypass_run(200);
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
